// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit 5-stage pipeline.
// Define FETCH_PERF_CNT_EN to build the saturating fetch/stall/flush performance counters.
module fetch_stage #(
    parameter int                   PC_W        = 16,
    parameter int                   INSTR_W     = 16,
    parameter logic [PC_W-1:0]      RESET_PC    = 16'h0000,
    parameter logic [3:0]           HALT_OPCODE = 4'hF,
    parameter logic [INSTR_W-1:0]   NOP_INSTR   = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_mem,
    input  logic               stall_br,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr_FD,
    output logic [PC_W-1:0]    pc_FD,
    output logic [PC_W-1:0]    pcInc_FD,
    output logic               valid_FD,
    output logic               halt_FD,
    output logic               halted,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DROP,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] req_addr, req_addr_nxt;
    logic            hold, accept, is_halt;
    logic            fd_load, fd_clear;

    assign hold    = stall_mem | stall_br;
    assign accept  = (state == S_FETCH) & imem_valid & ~hold & ~br_taken;
    assign is_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

    assign imem_req  = (state != S_HALT);
    assign imem_addr = (state == S_DROP) ? req_addr : pc;
    assign halted    = (state == S_HALT);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        fd_load      = 1'b0;
        fd_clear     = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (br_taken) begin
                    pc_nxt   = br_target;
                    fd_clear = 1'b1;
                    // An outstanding miss must be drained at its original address before redirecting.
                    if (!imem_valid) begin
                        req_addr_nxt = pc;
                        state_nxt    = S_DROP;
                    end
                end else if (hold) begin
                    // Returned data is discarded and re-requested at the same pc.
                end else if (imem_valid) begin
                    fd_load = 1'b1;
                    if (is_halt) state_nxt = S_HALT;
                    else         pc_nxt    = pc + PC_W'(2);
                end else begin
                    fd_clear = 1'b1;
                end
            end
            S_DROP: begin
                if (br_taken) begin
                    pc_nxt   = br_target;
                    fd_clear = 1'b1;
                end else begin
                    fd_clear = ~hold;
                    if (imem_valid) state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    fd_clear  = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    fd_clear = ~hold;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            instr_FD <= NOP_INSTR;
            pc_FD    <= '0;
            pcInc_FD <= '0;
            valid_FD <= 1'b0;
            halt_FD  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            req_addr <= req_addr_nxt;
            if (fd_clear) begin
                instr_FD <= NOP_INSTR;
                valid_FD <= 1'b0;
                halt_FD  <= 1'b0;
            end else if (fd_load) begin
                instr_FD <= imem_rdata;
                pc_FD    <= pc;
                pcInc_FD <= pc + PC_W'(2);
                valid_FD <= 1'b1;
                halt_FD  <= is_halt;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 16'd1;
            if (hold && state != S_HALT && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
            if (br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
